ecc_uart_tx_ctrl: RTL and testbench

ECC_UART_TX_CTRL -- requirements
Module: ecc_uart_tx_ctrl

---
 rtl/ecc_uart_tx_ctrl_pkg.sv | 18 +
 rtl/ecc_uart_tx_ctrl_hamming13_encoder.sv | 26 ++
 rtl/ecc_uart_tx_ctrl.sv | 139 +++++++++++++
 tb/tb_ecc_uart_tx_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_uart_tx_ctrl_pkg.sv
// Shared types and constants for the SECDED-protected UART transmit controller.
// Frame = start bit + 13-bit Hamming(13,8) codeword + stop bit.
package ecc_uart_tx_ctrl_pkg;

    localparam int DATA_W     = 8;
    localparam int CW_W       = 13;
    localparam int FRAME_BITS = 15;
    localparam int CNT_W      = 16;
    localparam int IDX_W      = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/ecc_uart_tx_ctrl_hamming13_encoder.sv
// Hamming(13,8) SECDED encoder.
// Layout {p_total,d8,d7,d6,d5,p8,d4,d3,d2,p4,d1,p2,p1}.
module hamming13_encoder
    import ecc_uart_tx_ctrl_pkg::*;
(
    input  logic [DATA_W-1:0] data_i,
    output logic [CW_W-1:0]   cw_o
);

    logic d1, d2, d3, d4, d5, d6, d7, d8;
    logic p1, p2, p4, p8;
    logic [CW_W-2:0] body;

    assign {d8, d7, d6, d5, d4, d3, d2, d1} = data_i;

    assign p1 = d1 ^ d2 ^ d4 ^ d5 ^ d7;
    assign p2 = d1 ^ d3 ^ d4 ^ d6 ^ d7;
    assign p4 = d2 ^ d3 ^ d4 ^ d8;
    assign p8 = d5 ^ d6 ^ d7 ^ d8;

    assign body = {d8, d7, d6, d5, p8, d4, d3, d2, p4, d1, p2, p1};

    // Overall parity makes the full word even, enabling double-error detect.
    assign cw_o = {^body, body};

endmodule

// File: rtl/ecc_uart_tx_ctrl.sv
// Two-requester round-robin UART transmitter sending each byte as a
// SECDED codeword: start, 13 codeword bits LSB first, stop.
module ecc_uart_tx_ctrl
    import ecc_uart_tx_ctrl_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic [DATA_W-1:0] data0,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              tx,
    output logic              busy,
    output logic              src_id,
    output logic              frame_done
);

    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_BITS - 3);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [CW_W-1:0]   cw_q, cw_d;
    logic              tx_q, tx_d;
    logic              src_q, src_d;
    logic              last_q, last_d;

    logic              any_req;
    logic              sel;
    logic              grant;
    logic              bit_end;
    logic [IDX_W-1:0]  idx_nx;
    logic [DATA_W-1:0] mux_data;
    logic [CW_W-1:0]   enc_cw;

    // Contention goes to whoever was not served last.
    assign any_req  = req0 | req1;
    assign sel      = (req0 & req1) ? ~last_q : req1;
    assign mux_data = sel ? data1 : data0;
    assign grant    = rst_n & (state_q == IDLE) & any_req;

    hamming13_encoder u_enc (
        .data_i (mux_data),
        .cw_o   (enc_cw)
    );

    assign bit_end = (cnt_q == BIT_LAST);
    assign idx_nx  = idx_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        cw_d    = cw_q;
        tx_d    = tx_q;
        src_d   = src_q;
        last_d  = last_q;

        unique case (state_q)
            IDLE: begin
                tx_d  = 1'b1;
                cnt_d = '0;
                if (grant) begin
                    cw_d    = enc_cw;
                    src_d   = sel;
                    last_d  = sel;
                    tx_d    = 1'b0;
                    idx_d   = '0;
                    state_d = START;
                end
            end
            START: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    idx_d   = '0;
                    tx_d    = cw_q[0];
                    state_d = DATA;
                end
            end
            DATA: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    if (idx_q == IDX_LAST) begin
                        tx_d    = 1'b1;
                        state_d = STOP;
                    end else begin
                        idx_d = idx_nx;
                        tx_d  = cw_q[idx_nx];
                    end
                end
            end
            STOP: begin
                cnt_d = bit_end ? '0 : cnt_q + 1'b1;
                if (bit_end) begin
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                tx_d    = 1'b1;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            cw_q    <= '0;
            tx_q    <= 1'b1;
            src_q   <= 1'b0;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            cw_q    <= cw_d;
            tx_q    <= tx_d;
            src_q   <= src_d;
            last_q  <= last_d;
        end
    end

    assign gnt0       = grant & ~sel;
    assign gnt1       = grant & sel;
    assign tx         = tx_q;
    assign busy       = (state_q != IDLE);
    assign src_id     = src_q;
    assign frame_done = (state_q == STOP) & bit_end;

endmodule

// File: tb/tb_ecc_uart_tx_ctrl.sv
// Randomized self-checking bench for ecc_uart_tx_ctrl with a
// position-based Hamming reference model and serial-stream decoding.
module tb_ecc_uart_tx_ctrl;

    localparam int C         = 4;
    localparam int FRAME_CYC = 15 * C;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] data0, data1;
    logic       gnt0, gnt1;
    logic       tx, busy, src_id, frame_done;

    int errors = 0;
    int checks = 0;
    bit exp_last;

    always #5 clk = ~clk;

    ecc_uart_tx_ctrl #(.CLKS_PER_BIT(C)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0       (req0),
        .req1       (req1),
        .data0      (data0),
        .data1      (data1),
        .gnt0       (gnt0),
        .gnt1       (gnt1),
        .tx         (tx),
        .busy       (busy),
        .src_id     (src_id),
        .frame_done (frame_done)
    );

    // Classic Hamming: data in non-power-of-two positions, parity p covers
    // every position whose index has bit p set, then overall even parity.
    function automatic logic [12:0] model_cw(input logic [7:0] b);
        logic [12:0] w;
        int di;
        logic par;
        w  = '0;
        di = 0;
        for (int pos = 1; pos <= 12; pos++) begin
            if ((pos & (pos - 1)) != 0) begin
                w[pos-1] = b[di];
                di++;
            end
        end
        for (int p = 1; p <= 8; p = p * 2) begin
            par = 1'b0;
            for (int pos = 1; pos <= 12; pos++)
                if ((pos & p) != 0 && pos != p) par ^= w[pos-1];
            w[p-1] = par;
        end
        w[12] = ^w[11:0];
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit ok, output int waited,
                              output bit sel_o, output logic [7:0] byte_o);
        bit exp_sel;
        ok = 0; waited = 0; sel_o = 0; byte_o = '0;
        for (int i = 0; i < 50; i++) begin
            if (i > 0) step();
            #1;
            if (gnt0 === 1'b1 || gnt1 === 1'b1) begin
                waited  = i;
                exp_sel = (req0 && req1) ? !exp_last : req1;
                checks++;
                if (gnt0 !== 1'(!exp_sel) || gnt1 !== 1'(exp_sel)) begin
                    errors++;
                    $display("FAIL arb: gnt0=%b gnt1=%b want gnt0=%b gnt1=%b",
                             gnt0, gnt1, !exp_sel, exp_sel);
                end
                checks++;
                if (busy !== 1'b0 || tx !== 1'b1) begin
                    errors++;
                    $display("FAIL grant_idle: busy=%b tx=%b want 0 1", busy, tx);
                end
                exp_last = exp_sel;
                sel_o    = exp_sel;
                byte_o   = exp_sel ? data1 : data0;
                ok       = 1;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL grant_timeout: no grant in 50 cycles, want one");
    endtask

    task automatic check_frame(input bit exp_src, input logic [12:0] exp_cw,
                               input logic [7:0] exp_byte, input bit drop,
                               input string tag);
        logic [14:0] stream, rx;
        stream = {1'b1, exp_cw, 1'b0};
        rx     = '0;
        for (int c = 1; c <= FRAME_CYC; c++) begin
            step();
            if (drop) begin
                req0  = 1'b0;
                req1  = 1'b0;
                data0 = 8'($urandom);
                data1 = 8'($urandom);
            end
            #1;
            checks++;
            if (tx !== stream[(c-1)/C]) begin
                errors++;
                $display("FAIL %s tx c=%0d: got %b want %b",
                         tag, c, tx, stream[(c-1)/C]);
            end
            checks++;
            if (busy !== 1'b1 || gnt0 !== 1'b0 || gnt1 !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_gnt c=%0d: busy=%b gnt=%b%b want 1 00",
                         tag, c, busy, gnt0, gnt1);
            end
            checks++;
            if (frame_done !== 1'(c == FRAME_CYC)) begin
                errors++;
                $display("FAIL %s frame_done c=%0d: got %b want %b",
                         tag, c, frame_done, c == FRAME_CYC);
            end
            if (c == 1) begin
                checks++;
                if (src_id !== exp_src) begin
                    errors++;
                    $display("FAIL %s src_id: got %b want %b", tag, src_id, exp_src);
                end
            end
            if ((c - 1) % C == C / 2) rx[(c-1)/C] = tx;
        end
        checks++;
        if (rx !== stream) begin
            errors++;
            $display("FAIL %s decode: got %h want %h", tag, rx, stream);
        end
        checks++;
        if ({rx[12:9], rx[7:5], rx[3]} !== exp_byte) begin
            errors++;
            $display("FAIL %s payload: got %h want %h",
                     tag, {rx[12:9], rx[7:5], rx[3]}, exp_byte);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n    = 1'b1;
        exp_last = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h5A;
        data1 = 8'hC3;
        repeat (3) step();
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_line: tx=%b busy=%b want 1 0", tx, busy);
        end
        checks++;
        if (gnt0 !== 1'b0 || gnt1 !== 1'b0 || frame_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_pulses: gnt=%b%b done=%b want 000",
                     gnt0, gnt1, frame_done);
        end
        checks++;
        if (src_id !== 1'b0) begin
            errors++;
            $display("FAIL reset_src: got %b want 0", src_id);
        end
        step();
        rst_n    = 1'b1;
        req0     = 1'b0;
        req1     = 1'b0;
        exp_last = 1'b1;
        step();
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: tx=%b busy=%b want 1 0", tx, busy);
        end
    endtask

    task automatic test_single_ff();
        bit ok, s; int w; logic [7:0] b;
        step();
        req0  = 1'b1;
        data0 = 8'hFF;
        wait_grant(ok, w, s, b);
        if (ok) check_frame(1'b0, 13'h0F77, 8'hFF, 1'b1, "ff");
    endtask

    task automatic test_single_01();
        bit ok, s; int w; logic [7:0] b;
        step();
        req1  = 1'b1;
        data1 = 8'h01;
        wait_grant(ok, w, s, b);
        if (ok) check_frame(1'b1, 13'h1007, 8'h01, 1'b1, "x01");
    endtask

    task automatic test_back_to_back();
        bit ok, s; int w; logic [7:0] b;
        do_reset();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'h00;
        data1 = 8'hA5;
        for (int f = 0; f < 4; f++) begin
            wait_grant(ok, w, s, b);
            if (!ok) break;
            if (f > 0) begin
                checks++;
                if (w != 0) begin
                    errors++;
                    $display("FAIL b2b_gap: waited %0d cycles want 0", w);
                end
            end
            check_frame(s, model_cw(b), b, 1'b0, "b2b");
            step();
        end
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_hold_change();
        bit ok, s; int w; logic [7:0] b;
        step();
        req0  = 1'b1;
        req1  = 1'b1;
        data0 = 8'($urandom);
        data1 = 8'($urandom);
        wait_grant(ok, w, s, b);
        if (ok) check_frame(s, model_cw(b), b, 1'b1, "hold");
    endtask

    task automatic test_reset_midframe();
        bit ok, s; int w; logic [7:0] b;
        step();
        req0  = 1'b1;
        data0 = 8'($urandom);
        wait_grant(ok, w, s, b);
        if (!ok) return;
        for (int c = 1; c < 30; c++) begin
            step();
            req0 = 1'b0;
        end
        step();
        req0  = 1'b1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_line: tx=%b busy=%b want 1 0", tx, busy);
        end
        checks++;
        if (frame_done !== 1'b0 || gnt0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_pulse: done=%b gnt0=%b want 0 0", frame_done, gnt0);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            #1;
            checks++;
            if (frame_done !== 1'b0 || tx !== 1'b1) begin
                errors++;
                $display("FAIL midrst_hold: done=%b tx=%b want 0 1", frame_done, tx);
            end
        end
        step();
        rst_n    = 1'b1;
        exp_last = 1'b1;
        data0    = 8'($urandom);
        wait_grant(ok, w, s, b);
        if (!ok) return;
        checks++;
        if (w != 0) begin
            errors++;
            $display("FAIL midrst_regrant: waited %0d want 0", w);
        end
        check_frame(s, model_cw(b), b, 1'b1, "postrst");
    endtask

    task automatic test_random();
        bit ok, s; int w; logic [7:0] b; int r; bit drop;
        for (int f = 0; f < 30; f++) begin
            step();
            r     = $urandom_range(1, 3);
            req0  = r[0];
            req1  = r[1];
            data0 = 8'($urandom);
            data1 = 8'($urandom);
            drop  = 1'($urandom_range(0, 1));
            wait_grant(ok, w, s, b);
            if (!ok) break;
            check_frame(s, model_cw(b), b, drop, "rand");
        end
        step();
        req0 = 1'b0;
        req1 = 1'b0;
    endtask

    task automatic test_all_bytes();
        bit ok, s; int w; logic [7:0] b, v;
        for (int i = 0; i < 256; i++) begin
            step();
            v = 8'(i);
            if (v[0]) begin
                req1  = 1'b1;
                data1 = v;
            end else begin
                req0  = 1'b1;
                data0 = v;
            end
            wait_grant(ok, w, s, b);
            if (!ok) break;
            check_frame(v[0], model_cw(v), v, 1'b1, "all");
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        req0     = 1'b0;
        req1     = 1'b0;
        data0    = '0;
        data1    = '0;
        exp_last = 1'b1;
        test_reset();
        test_single_ff();
        test_single_01();
        test_back_to_back();
        test_hold_change();
        test_reset_midframe();
        test_random();
        test_all_bytes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
